// File: rtl/wb_pkg.sv
// Shared write-back definitions: destination-mode encodings, result source indices,
// the stage state encoding and the link register number.
package wb_pkg;

  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_LINK = 2'b10;
  localparam logic [1:0] DST_NONE = 2'b11;

  localparam int SRC_ALU  = 0;
  localparam int SRC_DM   = 1;
  localparam int SRC_PC8  = 2;
  localparam int SRC_HILO = 3;
  localparam int SRC_CP0  = 4;

  localparam int LINK_REG = 31;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FULL  = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_dst_sel.sv
// Destination decode: maps a dst_mode plus rt/rd candidates to a GRF write address and enable.
// Writes to register 0 are suppressed so downstream logic never sees them.
module wb_dst_sel
  import wb_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [1:0]    dst_mode,
  input  logic [AW-1:0] rt,
  input  logic [AW-1:0] rd,
  output logic [AW-1:0] a3,
  output logic          we
);

  always_comb begin
    a3 = '0;
    case (dst_mode)
      DST_RT:   a3 = rt;
      DST_RD:   a3 = rd;
      DST_LINK: a3 = AW'(LINK_REG);
      default:  a3 = '0;
    endcase
    we = (dst_mode != DST_NONE) && (a3 != '0);
  end

endmodule

// File: rtl/wb_sel_stage.sv
// Write-back select stage: holds one instruction, waits for its result source, then emits one GRF write.
// Define WB_SEL_FWD_EN to add the fwd_valid/fwd_a3/fwd_data forwarding outputs.
module wb_sel_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NSRC   = 5,
  parameter int SEL_W  = $clog2(NSRC),
  parameter int AW     = 5,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [1:0]             in_dst_mode,
  input  logic [AW-1:0]          in_rt,
  input  logic [AW-1:0]          in_rd,
  input  logic [NSRC*DATA_W-1:0] src_data,
  input  logic [NSRC-1:0]        src_vld,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [AW-1:0]          out_a3,
  output logic [DATA_W-1:0]      out_wd,
  output logic [CNT_W-1:0]       stall_cnt
`ifdef WB_SEL_FWD_EN
  ,
  output logic                   fwd_valid,
  output logic [AW-1:0]          fwd_a3,
  output logic [DATA_W-1:0]      fwd_data
`endif
);

  wb_state_t         state;
  logic [SEL_W-1:0]  sel_q;
  logic [AW-1:0]     a3_q;
  logic              we_q;
  logic [AW-1:0]     out_a3_q;
  logic              out_we_q;
  logic [DATA_W-1:0] wd_q;

  logic              accept;
  logic [AW-1:0]     dec_a3;
  logic              dec_we;
  logic [DATA_W-1:0] in_word;
  logic              in_ok;
  logic [DATA_W-1:0] q_word;
  logic              q_ok;

  wb_dst_sel #(.AW(AW)) u_dst_sel (
    .dst_mode (in_dst_mode),
    .rt       (in_rt),
    .rd       (in_rd),
    .a3       (dec_a3),
    .we       (dec_we)
  );

  assign in_ready = (state != ST_WAIT) && !flush;
  assign accept   = in_valid && in_ready;

  // Out-of-range selects read as a zero word that is always valid.
  always_comb begin
    in_word = '0;
    in_ok   = 1'b1;
    q_word  = '0;
    q_ok    = 1'b1;
    for (int i = 0; i < NSRC; i++) begin
      if (in_sel == SEL_W'(i)) begin
        in_word = src_data[i*DATA_W +: DATA_W];
        in_ok   = src_vld[i];
      end
      if (sel_q == SEL_W'(i)) begin
        q_word = src_data[i*DATA_W +: DATA_W];
        q_ok   = src_vld[i];
      end
    end
  end

  // Pending address/enable live in a3_q/we_q; the out_* registers only change when a write is presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_EMPTY;
      sel_q     <= '0;
      a3_q      <= '0;
      we_q      <= 1'b0;
      out_a3_q  <= '0;
      out_we_q  <= 1'b0;
      wd_q      <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else if (accept) begin
      sel_q <= in_sel;
      a3_q  <= dec_a3;
      we_q  <= dec_we;
      if (in_ok) begin
        state    <= ST_FULL;
        out_a3_q <= dec_a3;
        out_we_q <= dec_we;
        wd_q     <= in_word;
      end else begin
        state <= ST_WAIT;
      end
    end else if (state == ST_WAIT) begin
      if (q_ok) begin
        state    <= ST_FULL;
        out_a3_q <= a3_q;
        out_we_q <= we_q;
        wd_q     <= q_word;
      end else if (stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end else begin
      state <= ST_EMPTY;
    end
  end

  assign out_valid = (state == ST_FULL) && out_we_q && !flush;
  assign out_a3    = out_a3_q;
  assign out_wd    = wd_q;

`ifdef WB_SEL_FWD_EN
  assign fwd_valid = (state == ST_FULL) && out_we_q && !flush;
  assign fwd_a3    = out_a3_q;
  assign fwd_data  = wd_q;
`endif

endmodule

// File: tb/tb_wb_sel_stage.sv
// Self-checking bench for wb_sel_stage: directed scenarios plus randomized traffic against a
// behavioural model of held instructions and pending writes.
module tb_wb_sel_stage;

  localparam int DATA_W = 32;
  localparam int NSRC   = 5;
  localparam int SEL_W  = $clog2(NSRC);
  localparam int AW     = 5;
  localparam int CNT_W  = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [SEL_W-1:0]       in_sel;
  logic [1:0]             in_dst_mode;
  logic [AW-1:0]          in_rt;
  logic [AW-1:0]          in_rd;
  logic [NSRC*DATA_W-1:0] src_data;
  logic [NSRC-1:0]        src_vld;
  logic                   flush;
  logic                   out_valid;
  logic [AW-1:0]          out_a3;
  logic [DATA_W-1:0]      out_wd;
  logic [CNT_W-1:0]       stall_cnt;
`ifdef WB_SEL_FWD_EN
  logic                   fwd_valid;
  logic [AW-1:0]          fwd_a3;
  logic [DATA_W-1:0]      fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  wb_sel_stage #(
    .DATA_W(DATA_W), .NSRC(NSRC), .SEL_W(SEL_W), .AW(AW), .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sel      (in_sel),
    .in_dst_mode (in_dst_mode),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .src_data    (src_data),
    .src_vld     (src_vld),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_a3      (out_a3),
    .out_wd      (out_wd),
    .stall_cnt   (stall_cnt)
`ifdef WB_SEL_FWD_EN
    ,
    .fwd_valid   (fwd_valid),
    .fwd_a3      (fwd_a3),
    .fwd_data    (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  // Model: an instruction is either held (waiting on its source) or has a write presented next cycle.
  bit                m_held;
  bit                m_out;
  bit                m_we;
  logic [AW-1:0]     m_a3;
  logic [DATA_W-1:0] m_wd;
  int                m_sel;
  int                m_stall;

  function automatic logic [DATA_W-1:0] word_of(int s);
    return (s < NSRC) ? src_data[s*DATA_W +: DATA_W] : '0;
  endfunction

  function automatic bit avail(int s);
    return (s < NSRC) ? src_vld[s] : 1'b1;
  endfunction

  task automatic model_reset();
    m_held = 0; m_out = 0; m_we = 0; m_a3 = '0; m_wd = '0; m_sel = 0; m_stall = 0;
  endtask

  task automatic model_edge();
    if (flush) begin
      m_held = 0;
      m_out  = 0;
    end else if (m_held) begin
      if (avail(m_sel)) begin
        m_held = 0; m_out = 1; m_wd = word_of(m_sel);
      end else begin
        m_out = 0;
        if (m_stall < (1 << CNT_W) - 1) m_stall++;
      end
    end else begin
      m_out = 0;
      if (in_valid) begin
        m_sel = int'(in_sel);
        case (in_dst_mode)
          2'd0:    m_a3 = in_rt;
          2'd1:    m_a3 = in_rd;
          2'd2:    m_a3 = 5'd31;
          default: m_a3 = '0;
        endcase
        m_we = (in_dst_mode != 2'd3) && (m_a3 != '0);
        if (avail(m_sel)) begin
          m_out = 1; m_wd = word_of(m_sel);
        end else begin
          m_held = 1;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input int sel, input logic [1:0] mode,
                        input logic [AW-1:0] rt, input logic [AW-1:0] rd);
    in_valid = v; in_sel = SEL_W'(sel); in_dst_mode = mode; in_rt = rt; in_rd = rd;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; src_data = '0; src_vld = '0;
    set_in(1'b0, 0, 2'd0, '0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1; reset = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b0 || out_a3 !== '0 || out_wd !== '0 || stall_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got v=%b a3=%0d wd=%h cnt=%0d, want all zero", out_valid, out_a3, out_wd, stall_cnt);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < NSRC; i++) src_data[i*DATA_W +: DATA_W] = $urandom;
    src_data[31:0] = 32'h1234; src_vld = '1;
    set_in(1'b1, 0, 2'b01, 5'd3, 5'd8);
    #1; tick(); in_valid = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b1 || out_a3 !== 5'd8 || out_wd !== 32'h1234) begin
      errors++; $display("[TB] FAIL basic_write: got v=%b a3=%0d wd=%h, want v=1 a3=8 wd=1234", out_valid, out_a3, out_wd);
    end
    checks++;
    if (stall_cnt !== '0) begin
      errors++; $display("[TB] FAIL basic_stall: got %0d want 0", stall_cnt);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_single_pulse: got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] w1, w2;
    w1 = $urandom; w2 = $urandom;
    src_data[1*DATA_W +: DATA_W] = w1; src_data[2*DATA_W +: DATA_W] = w2; src_vld = '1;
    set_in(1'b1, 1, 2'b10, 5'd4, 5'd6);
    #1; tick();
    set_in(1'b1, 2, 2'b10, 5'd4, 5'd6); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_a3 !== 5'd31 || out_wd !== w1) begin
      errors++; $display("[TB] FAIL b2b_first: got rdy=%b v=%b a3=%0d wd=%h, want rdy=1 v=1 a3=31 wd=%h", in_ready, out_valid, out_a3, out_wd, w1);
    end
    tick(); in_valid = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b1 || out_a3 !== 5'd31 || out_wd !== w2) begin
      errors++; $display("[TB] FAIL b2b_second: got v=%b a3=%0d wd=%h, want v=1 a3=31 wd=%h", out_valid, out_a3, out_wd, w2);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_end: got %b want 0", out_valid);
    end
  endtask

  task automatic test_wait();
    src_vld = '1; src_vld[3] = 1'b0; src_data[3*DATA_W +: DATA_W] = 32'h5555;
    set_in(1'b1, 3, 2'b01, 5'd2, 5'd5);
    #1; tick(); in_valid = 1'b0; #1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL wait_hold c=%0d: got rdy=%b v=%b, want rdy=0 v=0", c, in_ready, out_valid);
      end
      tick();
    end
    src_vld[3] = 1'b1; src_data[3*DATA_W +: DATA_W] = 32'hDEAD; #1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_a3 !== 5'd5 || out_wd !== 32'hDEAD) begin
      errors++; $display("[TB] FAIL wait_write: got v=%b a3=%0d wd=%h, want v=1 a3=5 wd=dead", out_valid, out_a3, out_wd);
    end
    checks++;
    if (stall_cnt !== 16'd4) begin
      errors++; $display("[TB] FAIL wait_stall: got %0d want 4", stall_cnt);
    end
    tick();
  endtask

  task automatic test_no_write();
    src_vld = '1;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) set_in(1'b1, 0, 2'b00, 5'd0, 5'd9);
      else        set_in(1'b1, 1, 2'b11, 5'd7, 5'd7);
      #1; tick(); in_valid = 1'b0; #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL no_write k=%0d: got v=%b rdy=%b, want v=0 rdy=1", k, out_valid, in_ready);
      end
`ifdef WB_SEL_FWD_EN
      checks++;
      if (fwd_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL no_write_fwd k=%0d: got %b want 0", k, fwd_valid);
      end
`endif
      tick();
    end
  endtask

  task automatic test_flush();
    logic [DATA_W-1:0] w2;
    w2 = $urandom;
    src_vld = '1; src_vld[4] = 1'b0;
    set_in(1'b1, 4, 2'b01, 5'd1, 5'd10);
    #1; tick(); in_valid = 1'b0; #1;
    tick();
    flush = 1'b1; src_vld[4] = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_wait: got rdy=%b v=%b, want rdy=0 v=0", in_ready, out_valid);
    end
    tick(); flush = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || stall_cnt !== 16'd5) begin
      errors++; $display("[TB] FAIL flush_after: got rdy=%b v=%b cnt=%0d, want rdy=1 v=0 cnt=5", in_ready, out_valid, stall_cnt);
    end
    flush = 1'b1; set_in(1'b1, 0, 2'b01, 5'd1, 5'd9); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_accept_ready: got %b want 0", in_ready);
    end
    tick(); flush = 1'b0; in_valid = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_accept_dropped: got %b want 0", out_valid);
    end
    src_data[2*DATA_W +: DATA_W] = w2;
    set_in(1'b1, 2, 2'b00, 5'd12, 5'd3);
    #1; tick(); in_valid = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b1 || out_a3 !== 5'd12 || out_wd !== w2) begin
      errors++; $display("[TB] FAIL flush_resume: got v=%b a3=%0d wd=%h, want v=1 a3=12 wd=%h", out_valid, out_a3, out_wd, w2);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    src_vld = '1; src_vld[3] = 1'b0;
    set_in(1'b1, 3, 2'b01, 5'd2, 5'd14);
    #1; tick(); in_valid = 1'b0; #1;
    tick();
    #3; reset = 1'b1; model_reset(); #1;
    checks++;
    if (out_valid !== 1'b0 || out_a3 !== '0 || out_wd !== '0 || stall_cnt !== '0 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_mid_wait: got v=%b a3=%0d wd=%h cnt=%0d rdy=%b, want zeros and rdy=1", out_valid, out_a3, out_wd, stall_cnt, in_ready);
    end
    src_vld = '1;
    @(posedge clk); #1; reset = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL reset_no_late_write c=%0d: got %b want 0", c, out_valid);
      end
    end
  endtask

  task automatic test_random();
    bit ev;
    for (int c = 0; c < 400; c++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 7), 2'($urandom_range(0, 3)),
             AW'($urandom_range(0, 3)), AW'($urandom));
      for (int i = 0; i < NSRC; i++) begin
        src_data[i*DATA_W +: DATA_W] = $urandom;
        src_vld[i] = $urandom_range(0, 9) < 6;
      end
      flush = $urandom_range(0, 11) == 0;
      #1;
      ev = m_out && m_we && !flush;
      checks++;
      if (in_ready !== (!m_held && !flush)) begin
        errors++; $display("[TB] FAIL rand_ready c=%0d: got %b want %b", c, in_ready, !m_held && !flush);
      end
      checks++;
      if (out_valid !== ev) begin
        errors++; $display("[TB] FAIL rand_valid c=%0d: got %b want %b", c, out_valid, ev);
      end
      if (ev) begin
        checks++;
        if (out_a3 !== m_a3 || out_wd !== m_wd) begin
          errors++; $display("[TB] FAIL rand_data c=%0d: got a3=%0d wd=%h want a3=%0d wd=%h", c, out_a3, out_wd, m_a3, m_wd);
        end
      end
      checks++;
      if (stall_cnt !== CNT_W'(m_stall)) begin
        errors++; $display("[TB] FAIL rand_stall c=%0d: got %0d want %0d", c, stall_cnt, m_stall);
      end
`ifdef WB_SEL_FWD_EN
      checks++;
      if (fwd_valid !== ev || (ev && (fwd_a3 !== m_a3 || fwd_data !== m_wd))) begin
        errors++; $display("[TB] FAIL rand_fwd c=%0d: got v=%b a3=%0d d=%h want v=%b a3=%0d d=%h", c, fwd_valid, fwd_a3, fwd_data, ev, m_a3, m_wd);
      end
`endif
      tick();
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_wait();
    test_no_write();
    test_flush();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
